// File: rtl/multicycle_sequencer_if.sv
// Bus between the multicycle sequencer and the core around it:
// ROM fetch, decoder flags, branch inputs, data-memory handshake and status.
// master: sequencer side (drives PC, IR, strobes, status).
// slave:  core/memory side (drives start, instr, dec_*, br_*, mem_ack).
interface multicycle_sequencer_if #(
    parameter int D  = 10,
    parameter int IW = 9,
    parameter int CW = 16
);
    logic          start;
    logic [IW-1:0] instr;
    logic          dec_halt;
    logic          dec_mem;
    logic          dec_store;
    logic          dec_regw;
    logic          dec_branch;
    logic          dec_rel;
    logic          br_taken;
    logic [D-1:0]  br_target;
    logic          mem_ack;
    logic [D-1:0]  prog_ctr;
    logic [IW-1:0] ir;
    logic          mem_req;
    logic          mem_we;
    logic          rf_we;
    logic          alu_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] cycle_count;

    modport master (
        input  start, instr, dec_halt, dec_mem, dec_store, dec_regw,
               dec_branch, dec_rel, br_taken, br_target, mem_ack,
        output prog_ctr, ir, mem_req, mem_we, rf_we, alu_en, busy, done,
               error, cycle_count
    );

    modport slave (
        output start, instr, dec_halt, dec_mem, dec_store, dec_regw,
               dec_branch, dec_rel, br_taken, br_target, mem_ack,
        input  prog_ctr, ir, mem_req, mem_we, rf_we, alu_en, busy, done,
               error, cycle_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: owns PC, IR and datapath strobes (F/D/E/M/W FSM).
// Ports: clk, reset (async, active-high), bus (multicycle_sequencer_if.master).
// Latency: ALU 4, load 4+n, store 3+n, halt 2 cycles; MEM waits up to TMO cycles for ack.
module multicycle_sequencer #(
    parameter int D   = 10,
    parameter int IW  = 9,
    parameter int CW  = 16,
    parameter int TMO = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_sequencer_if.master bus
);
    localparam int TW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]    state;
    logic [D-1:0]  prog_ctr;
    logic [IW-1:0] ir;
    logic [CW-1:0] cycle_count;
    logic [TW-1:0] timer;
    logic          mem_r, store_r, regw_r, branch_r, rel_r;
    logic          taken;
    logic [D-1:0]  target;
    logic [D-1:0]  pc_next;
    logic          busy;

    // FETCH..WB occupy the contiguous encodings 1..5
    assign busy = (state >= S_FETCH) && (state <= S_WB);

    always_comb begin
        pc_next = prog_ctr + D'(1);
        if (taken && rel_r)
            pc_next = prog_ctr + target;
        else if (taken)
            pc_next = target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            prog_ctr    <= '0;
            ir          <= '0;
            cycle_count <= '0;
            timer       <= '0;
            mem_r       <= 1'b0;
            store_r     <= 1'b0;
            regw_r      <= 1'b0;
            branch_r    <= 1'b0;
            rel_r       <= 1'b0;
            taken       <= 1'b0;
            target      <= '0;
        end else begin
            if (busy && (cycle_count != {CW{1'b1}}))
                cycle_count <= cycle_count + CW'(1);
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        state       <= S_FETCH;
                        prog_ctr    <= '0;
                        cycle_count <= '0;
                    end
                end
                S_FETCH: begin
                    ir    <= bus.instr;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    mem_r    <= bus.dec_mem;
                    store_r  <= bus.dec_store;
                    regw_r   <= bus.dec_regw;
                    branch_r <= bus.dec_branch;
                    rel_r    <= bus.dec_rel;
                    state    <= bus.dec_halt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    taken  <= branch_r & bus.br_taken;
                    target <= bus.br_target;
                    timer  <= TW'(1);
                    state  <= mem_r ? S_MEM : S_WB;
                end
                S_MEM: begin
                    // ack is checked before the limit so an ack on the last
                    // permitted cycle still completes the access
                    if (bus.mem_ack) begin
                        if (store_r) begin
                            prog_ctr <= pc_next;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (timer == TW'(TMO)) begin
                        state <= S_ERR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WB: begin
                    prog_ctr <= pc_next;
                    state    <= S_FETCH;
                end
                S_ERR: state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs only: nothing here depends combinationally on inputs
    assign bus.prog_ctr    = prog_ctr;
    assign bus.ir          = ir;
    assign bus.cycle_count = cycle_count;
    assign bus.busy        = busy;
    assign bus.alu_en      = (state == S_EXEC);
    assign bus.mem_req     = (state == S_MEM);
    assign bus.mem_we      = (state == S_MEM) && store_r;
    assign bus.rf_we       = (state == S_WB) && regw_r;
    assign bus.done        = (state == S_HALT);
    assign bus.error       = (state == S_ERR);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: acts as ROM, decoder and data memory, and
// predicts per-instruction length, strobe counts, next PC and cycle count.
// A second instance with D=4, CW=3 covers PC wrap and counter saturation.
module tb_multicycle_sequencer;
    localparam int D = 10, IW = 9, CW = 16, TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.D(D), .IW(IW), .CW(CW)) sif ();
    multicycle_sequencer_if #(.D(4), .IW(IW), .CW(3))  sif2 ();

    multicycle_sequencer #(.D(D), .IW(IW), .CW(CW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .bus(sif.master));
    multicycle_sequencer #(.D(4), .IW(IW), .CW(3), .TMO(TMO)) dut2 (
        .clk(clk), .reset(reset), .bus(sif2.master));

    // Test program encoding: opcode in ir[8:6]
    // 0 alu+regw, 1 alu, 2 load, 3 store, 4 rel branch, 5 abs branch, 7 halt
    logic [IW-1:0] rom [0:1023];
    logic [2:0]    opc;
    assign sif.instr      = rom[sif.prog_ctr];
    assign opc            = sif.ir[8:6];
    assign sif.dec_halt   = (opc == 3'd7);
    assign sif.dec_mem    = (opc == 3'd2) || (opc == 3'd3);
    assign sif.dec_store  = (opc == 3'd3);
    assign sif.dec_regw   = (opc == 3'd0) || (opc == 3'd2);
    assign sif.dec_branch = (opc == 3'd4) || (opc == 3'd5);
    assign sif.dec_rel    = (opc == 3'd4);

    assign sif2.instr      = 9'h040;
    assign sif2.dec_halt   = 1'b0;
    assign sif2.dec_mem    = 1'b0;
    assign sif2.dec_store  = 1'b0;
    assign sif2.dec_regw   = 1'b0;
    assign sif2.dec_branch = 1'b0;
    assign sif2.dec_rel    = 1'b0;
    assign sif2.br_taken   = 1'b0;
    assign sif2.br_target  = '0;
    assign sif2.mem_ack    = 1'b0;

    int total = 0;
    int bad = 0;
    logic [D-1:0]  pc_m;
    logic [CW-1:0] cc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".prog_ctr"}, 32'(sif.prog_ctr), 0);
        chk({tag, ".ir"}, 32'(sif.ir), 0);
        chk({tag, ".cycle_count"}, 32'(sif.cycle_count), 0);
        chk({tag, ".strobes"}, {27'd0, sif.mem_req, sif.mem_we, sif.rf_we,
                                sif.alu_en, sif.busy}, 0);
        chk({tag, ".status"}, {30'd0, sif.done, sif.error}, 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        pc_m = '0;
        cc_m = '0;
    endtask

    // Entered at a negedge with the DUT in FETCH. n = MEM cycle carrying
    // the ack (0 = never ack). Leaves at the negedge after the instruction.
    task automatic do_instr(input int op, input int n, input bit tk, input logic [D-1:0] tgt);
        logic [IW-1:0] enc;
        bit is_mem, to;
        int m, len, busy_c, alu_c, rf_c, rf_pos, mem_c, we_c, mcnt;
        enc = {op[2:0], 6'($urandom)};
        rom[pc_m] = enc;
        sif.br_taken  = tk;
        sif.br_target = tgt;
        is_mem = (op == 2) || (op == 3);
        to     = is_mem && (n == 0);
        m      = is_mem ? (to ? TMO : n) : 0;
        if (op == 7)      len = 2;
        else if (op == 2) len = (to ? 3 : 4) + m;
        else if (op == 3) len = 3 + m;
        else              len = 4;
        busy_c = 0; alu_c = 0; rf_c = 0; rf_pos = -1; mem_c = 0; we_c = 0; mcnt = 0;
        for (int i = 0; i < len; i++) begin
            busy_c += int'(sif.busy);
            alu_c  += int'(sif.alu_en);
            if (sif.rf_we) begin rf_c++; rf_pos = i; end
            if (sif.mem_req) begin
                mem_c++;
                we_c += int'(sif.mem_we);
                mcnt++;
                sif.mem_ack = (mcnt == n);
            end else begin
                sif.mem_ack = 1'($urandom);
            end
            sif.start = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        sif.start   = 1'b0;
        sif.mem_ack = 1'b0;
        cc_m = (int'(cc_m) + len > 65535) ? 16'hFFFF : cc_m + CW'(len);
        chk($sformatf("op%0d.busy_cycles", op), busy_c, len);
        chk($sformatf("op%0d.alu_en_cycles", op), alu_c, (op == 7) ? 0 : 1);
        chk($sformatf("op%0d.rf_we_cycles", op), rf_c, (op == 0 || op == 2) ? 1 : 0);
        if (rf_c == 1) chk($sformatf("op%0d.rf_we_pos", op), rf_pos, len - 1);
        chk($sformatf("op%0d.mem_req_cycles", op), mem_c, m);
        chk($sformatf("op%0d.mem_we_cycles", op), we_c, (op == 3) ? m : 0);
        chk($sformatf("op%0d.ir", op), 32'(sif.ir), 32'(enc));
        chk($sformatf("op%0d.cycle_count", op), 32'(sif.cycle_count), 32'(cc_m));
        if (to) begin
            chk("timeout.error", 32'(sif.error), 1);
            chk("timeout.mem_req", 32'(sif.mem_req), 0);
            chk("timeout.busy", 32'(sif.busy), 0);
        end else begin
            if ((op == 4 || op == 5) && tk)
                pc_m = (op == 4) ? pc_m + tgt : tgt;
            else if (op != 7)
                pc_m = pc_m + 1'b1;
            chk($sformatf("op%0d.prog_ctr", op), 32'(sif.prog_ctr), 32'(pc_m));
            if (op == 7) chk("halt.done", 32'(sif.done), 1);
            else         chk($sformatf("op%0d.busy_next", op), 32'(sif.busy), 1);
        end
    endtask

    initial begin
        int ops [6] = '{0, 1, 2, 3, 4, 5};
        for (int i = 0; i < 1024; i++) rom[i] = 9'h1C0;
        sif.start = 1'b0; sif.br_taken = 1'b0; sif.br_target = '0; sif.mem_ack = 1'b0;
        sif2.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;

        // narrow instance: PC wrap 15 -> 0 and counter saturation at 7
        @(negedge clk);
        sif2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif2.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("narrow.pc1", 32'(sif2.prog_ctr), 1);
        chk("narrow.cc4", 32'(sif2.cycle_count), 4);
        repeat (56) @(negedge clk);
        chk("narrow.pc15", 32'(sif2.prog_ctr), 15);
        repeat (4) @(negedge clk);
        chk("narrow.pc_wrap", 32'(sif2.prog_ctr), 0);
        chk("narrow.cc_sat", 32'(sif2.cycle_count), 7);

        // ALU then halt
        do_start();
        do_instr(0, 0, 0, '0);
        do_instr(7, 0, 0, '0);
        chk("prog1.cycle_count", 32'(sif.cycle_count), 6);

        // restart from HALT, load at PC 5, branches at PC 3
        do_start();
        do_instr(5, 0, 1, 10'd5);
        do_instr(2, 3, 0, '0);
        do_instr(5, 0, 1, 10'd3);
        do_instr(4, 0, 1, 10'h3FE);
        do_instr(5, 0, 1, 10'd3);
        do_instr(5, 0, 1, 10'd200);
        do_instr(5, 0, 1, 10'd3);
        do_instr(4, 0, 0, 10'($urandom));
        do_instr(3, TMO, 0, '0);
        do_instr(2, TMO, 0, '0);
        do_instr(1, 0, 1, 10'($urandom));

        for (int k = 0; k < 40; k++)
            do_instr(ops[$urandom_range(0, 5)], $urandom_range(1, TMO),
                     1'($urandom), 10'($urandom));
        do_instr(7, 0, 0, '0);

        // store with no ack -> ERR; start ignored there
        do_start();
        do_instr(3, 0, 0, '0);
        sif.start = 1'b1;
        repeat (2) @(negedge clk);
        sif.start = 1'b0;
        chk("err.sticky", 32'(sif.error), 1);
        chk("err.start_ignored", 32'(sif.busy), 0);
        reset = 1'b1;
        #1 chk_idle("reset_err");
        @(negedge clk);
        reset = 1'b0;

        // reset in the middle of MEM
        do_start();
        rom[0] = 9'h080;
        sif.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("midmem.mem_req", 32'(sif.mem_req), 1);
        reset = 1'b1;
        #1 chk_idle("reset_mem");
        @(negedge clk);
        reset = 1'b0;

        // reset while halted, then resume from PC 0
        do_start();
        do_instr(7, 0, 0, '0);
        reset = 1'b1;
        #1 chk_idle("reset_halt");
        @(negedge clk);
        reset = 1'b0;
        do_start();
        do_instr(0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
